// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: load/store bus controller with core stall, fault pulses and bus timeout
module dmem_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        load_type,
  input  logic              store_type,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              misaligned,
  output logic              bus_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_be,
  input  logic              bus_ready,
  input  logic [31:0]       bus_rdata
);
  localparam int CW = TIMEOUT > 2 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [ADDR_W-1:0] cap_addr;
  logic [31:0] cap_wd, result, lane_ext;
  logic [3:0] cap_be;
  logic [1:0] cap_lt;
  logic [7:0] lane;
  logic cap_we, err, valid, fault, start, term;
  assign valid = mem_read | mem_write;
  assign fault = mem_write ? (!store_type && addr[1:0] != 2'b00)
                           : (load_type == 2'b11 || (load_type == 2'b00 && addr[1:0] != 2'b00));
  assign start = state == IDLE && valid && !fault;
  assign term = state == WAIT && !bus_ready && cnt == CW'(TIMEOUT - 1);
  assign lane = bus_rdata[8*cap_addr[1:0] +: 8];
  assign lane_ext = cap_lt == 2'b01 ? {24'h0, lane} :
                    cap_lt == 2'b10 ? {{24{lane[7]}}, lane} : bus_rdata;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state == IDLE ? (start ? WAIT : IDLE) :
              state == WAIT ? (bus_ready || term ? DONE : WAIT) : IDLE;
  end
  // Write-side lane data and enables are resolved at capture so the bus sees plain registers in WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      cap_addr <= '0;
      cap_wd <= '0;
      cap_be <= '0;
      cap_lt <= '0;
      cap_we <= 1'b0;
      result <= '0;
      err <= 1'b0;
    end else begin
      cnt <= state == WAIT && !bus_ready && !term ? cnt + CW'(1) : '0;
      if (start) begin
        cap_addr <= addr;
        cap_lt <= load_type;
        cap_we <= mem_write;
        cap_be <= mem_write && store_type ? 4'b0001 << addr[1:0] : 4'hF;
        cap_wd <= !mem_write ? 32'h0 : store_type ? {4{wdata[7:0]}} : wdata;
      end
      if (state == WAIT) begin
        result <= bus_ready && !cap_we ? lane_ext : 32'h0;
        err <= !bus_ready;
      end
    end
  end
  always_comb begin
    stall = start || state == WAIT;
    misaligned = state == IDLE && valid && fault;
    bus_req = state == WAIT;
    bus_we = state == WAIT && cap_we;
    bus_addr = state == WAIT ? {cap_addr[ADDR_W-1:2], 2'b00} : '0;
    bus_wdata = state == WAIT ? cap_wd : 32'h0;
    bus_be = state == WAIT ? cap_be : 4'h0;
    rdata = state == DONE ? result : 32'h0;
    bus_err = state == DONE && err;
  end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed and random transactions checked against a behavioural load/store model
module tb_dmem_access_ctrl;
  localparam int TIMEOUT = 16;
  logic clk = 0, rst = 1, mem_read = 0, mem_write = 0, store_type = 0, bus_ready = 0;
  logic [1:0] load_type = 0;
  logic [31:0] addr = 0, wdata = 0, bus_rdata = 0;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0] bus_be;
  logic stall, misaligned, bus_err, bus_req, bus_we;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .load_type(load_type), .store_type(store_type), .addr(addr), .wdata(wdata),
    .rdata(rdata), .stall(stall), .misaligned(misaligned), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // k = WAIT cycle on which bus_ready arrives; k > TIMEOUT means the slave never answers
  task automatic access(input logic rd, input logic wr, input logic [1:0] lt, input logic st,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat, input int k);
    logic word, fault, to;
    logic [31:0] lane, exp_rd, exp_be, exp_wd;
    int last;
    word = wr ? !st : (lt == 2'd0);
    fault = (word && a[1:0] != 2'd0) || (!wr && lt == 2'd3);
    to = k > TIMEOUT;
    lane = (rdat >> (8 * a[1:0])) & 32'hFF;
    exp_rd = (to || wr) ? 32'h0 : lt == 2'd1 ? lane :
             lt == 2'd2 ? (lane | (lane >= 32'h80 ? 32'hFFFF_FF00 : 32'h0)) : rdat;
    exp_be = (wr && st) ? (32'd1 << a[1:0]) : 32'hF;
    exp_wd = !wr ? 32'h0 : st ? wd[7:0] * 32'h0101_0101 : wd;
    step();
    mem_read = rd; mem_write = wr; load_type = lt; store_type = st; addr = a; wdata = wd;
    bus_ready = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
    @(negedge clk);
    chk("req_stall", stall, !fault);
    chk("req_misaligned", misaligned, fault);
    chk("req_bus_req", bus_req, 0);
    step();
    mem_read = 0; mem_write = 0; addr = $urandom; wdata = $urandom; bus_ready = 0;
    if (fault) begin
      @(negedge clk);
      chk("flt_stall", stall, 0);
      chk("flt_bus_req", bus_req, 0);
      chk("flt_misaligned", misaligned, 0);
      return;
    end
    last = to ? TIMEOUT : k;
    for (int w = 1; w <= last; w++) begin
      bus_ready = (w == k);
      bus_rdata = (w == k) ? rdat : $urandom;
      @(negedge clk);
      chk("wait_bus_req", bus_req, 1);
      chk("wait_stall", stall, 1);
      chk("wait_bus_addr", bus_addr, {a[31:2], 2'b00});
      chk("wait_bus_we", bus_we, wr);
      chk("wait_bus_be", bus_be, exp_be);
      chk("wait_bus_wdata", bus_wdata, exp_wd);
      chk("wait_rdata", rdata, 0);
      chk("wait_bus_err", bus_err, 0);
      step();
    end
    bus_ready = 0; bus_rdata = $urandom;
    mem_read = rd; mem_write = wr; load_type = lt; addr = a;
    @(negedge clk);
    chk("done_stall", stall, 0);
    chk("done_bus_req", bus_req, 0);
    chk("done_rdata", rdata, exp_rd);
    chk("done_bus_err", bus_err, to);
    step();
    mem_read = 0; mem_write = 0;
    @(negedge clk);
    chk("idle_stall", stall, 0);
    chk("idle_bus_req", bus_req, 0);
    chk("idle_rdata", rdata, 0);
    chk("idle_bus_err", bus_err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic rd, wr, st;
    logic [1:0] lt;
    int r, k;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_bus_be", bus_be, 0);
    chk("rst_bus_addr", bus_addr, 0);
    rst = 0;
    access(1, 0, 2'b10, 0, 32'h103, 0, 32'h80AA_BBCC, 2);
    access(1, 0, 2'b01, 0, 32'h101, 0, 32'h80AA_BBCC, 1);
    access(1, 0, 2'b00, 0, 32'h104, 0, 32'h1234_5678, 1);
    access(0, 1, 2'b00, 1, 32'h102, 32'hDEAD_BE5A, 0, 3);
    access(1, 1, 2'b11, 0, 32'h108, 32'hCAFE_F00D, 0, 2);
    access(1, 0, 2'b00, 0, 32'h101, 0, 0, 1);
    access(1, 0, 2'b11, 0, 32'h100, 0, 0, 1);
    access(0, 1, 2'b00, 0, 32'h106, 32'h1111_2222, 0, 1);
    access(1, 0, 2'b00, 0, 32'h200, 0, 32'hA5A5_5A5A, TIMEOUT + 1);
    access(1, 0, 2'b00, 0, 32'h204, 0, 32'h0BAD_F00D, TIMEOUT);
    step();
    mem_read = 1; load_type = 2'b00; addr = 32'h300;
    @(negedge clk);
    chk("rstw_req_stall", stall, 1);
    step();
    mem_read = 0; rst = 1;
    @(negedge clk);
    chk("rstw_in_wait", bus_req, 1);
    step();
    rst = 0; bus_ready = 1;
    @(negedge clk);
    chk("rstw_bus_req", bus_req, 0);
    chk("rstw_stall", stall, 0);
    chk("rstw_rdata", rdata, 0);
    step();
    bus_ready = 0;
    @(negedge clk);
    chk("stray_ready_req", bus_req, 0);
    access(1, 0, 2'b00, 0, 32'h304, 0, 32'h7654_3210, 2);
    repeat (60) begin
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      lt = 2'($urandom_range(0, 3));
      st = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      k = r == 0 ? TIMEOUT + 1 : r == 1 ? TIMEOUT : $urandom_range(1, 4);
      access(rd, wr, lt, st, $urandom, $urandom, $urandom, k);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Data-memory access controller sitting directly downstream of the funct3 load/store-type decoder.
- Consumes the decoded load_type/store_type plus the ALU address and rs2 data.
- Runs a multi-cycle req/ready transaction on the data bus and returns an extended load result to writeback.
- Stalls the single-cycle core while a transaction is outstanding, and flags misaligned/illegal accesses and bus timeouts.

Parameters:
- ADDR_W, 32, byte-address width.
- TIMEOUT, 16, max cycles in WAIT without bus_ready before aborting (>=2).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- mem_read  in  1  current instruction is a load
- mem_write  in  1  current instruction is a store
- load_type  in  2  00 word, 01 byte zero-extend, 10 byte sign-extend, 11 illegal
- store_type  in  1  1 byte, 0 word
- addr  in  ADDR_W  byte address from ALU
- wdata  in  32  store data (rs2)
- rdata  out  32  extended load result, valid in DONE
- stall  out  1  hold PC/pipeline
- misaligned  out  1  one-cycle fault pulse
- bus_err  out  1  one-cycle timeout pulse
- bus_req  out  1  transaction request
- bus_we  out  1  1 write, 0 read
- bus_addr  out  ADDR_W  word-aligned address
- bus_wdata  out  32  lane-replicated write data
- bus_be  out  4  byte enables
- bus_ready  in  1  slave completion, one-cycle
- bus_rdata  in  32  read word, valid with bus_ready

Behaviour:
- States: IDLE, WAIT, DONE. Reset (synchronous on the clock edge, including mid-transaction) forces IDLE. All outputs 0, timeout counter 0, captured registers 0.
- Access valid in IDLE when mem_read or mem_write is 1. If both are 1, the write wins.
- Fault check in IDLE, combinational:
  - Word access (store_type=0 write, or load_type=00 read) with addr[1:0]!=0 → fault.
  - Read with load_type=11 → fault.
- On a fault:
  - misaligned=1 for that cycle; stall=0; no bus transaction; state stays IDLE.
  - rdata=0.
  - A faulting store writes nothing.
- On a valid non-faulting access in IDLE:
  - stall=1 combinationally in the same cycle.
  - Capture addr, wdata, load_type, store_type and op.
  - Next state WAIT.
- WAIT:
  - bus_req=1; stall=1.
  - bus_addr={addr[ADDR_W-1:2],2'b00}; bus_we=op.
  - bus_addr, bus_we, bus_wdata and bus_be come from registers and stay stable for the whole of WAIT.
- Store byte:
  - bus_wdata={4{wdata[7:0]}}; bus_be=4'b0001<<addr[1:0].
  - bus_be: addr[1:0]=0→0001, 1→0010, 2→0100, 3→1000.
- Store word: bus_wdata=wdata; bus_be=4'hF.
- Read: bus_be=4'hF; bus_wdata=0.
- bus_ready=1 in WAIT:
  - Next state DONE; bus_req drops at the next edge.
  - For loads, register the result:
    - Byte lane b=bus_rdata[8*addr[1:0]+:8].
    - 01→{24'h0,b}; 10→{{24{b[7]}},b}; 00→bus_rdata.
- Timeout counter:
  - Increments each WAIT cycle without bus_ready.
  - When it reaches TIMEOUT-1 without ready, next state is DONE with bus_err=1 in DONE and rdata=0.
  - Counter clears on leaving WAIT.
  - A bus_ready arriving in the same cycle as the terminal count wins: normal completion, no error.
- DONE (exactly one cycle):
  - stall=0; rdata holds the result; bus_req=0.
  - Next state IDLE unconditionally. A request present in DONE belongs to the completing instruction and is ignored.
- bus_ready outside WAIT is ignored.
- Latency:
  - Request in cycle T, bus_ready in cycle T+k (k>=1) → rdata valid and stall low in cycle T+k+1.
  - Zero-wait slave: k=1, total 3 cycles including DONE.
- rdata is 0 in IDLE and WAIT.

Test Plan:
- LB at addr 0x103, bus_rdata=0x80AA_BBCC, ready after 2 WAIT cycles → stall high 3 cycles; DONE rdata=0xFFFF_FF80; bus_addr=0x100, bus_be=4'hF.
- LBU at 0x101 with the same data, then LW at 0x104 with bus_rdata=0x1234_5678 → rdata 0x0000_00BB, then 0x1234_5678.
- SB at 0x102, wdata=0xDEAD_BE5A → bus_we=1, bus_be=0100, bus_wdata=0x5A5A_5A5A; SW at 0x108 → bus_be=1111, bus_wdata=wdata.
- LW at 0x101, load_type=11 at 0x100, and SW at 0x106 → misaligned pulses, bus_req never rises, stall stays 0.
- bus_ready held low → after TIMEOUT=16 WAIT cycles: DONE, bus_err=1, rdata=0, IDLE next. A repeat with ready arriving on the terminal cycle → no bus_err.
- rst asserted during WAIT → next cycle IDLE, bus_req=0, stall=0; a new LW then completes normally.
